// File: rtl/sf3_cmd_sequencer.sv
// sf3_cmd_sequencer: turns one high-level serial-flash command into quad-SPI driver
// transactions.
//
// For each accepted command the sequencer:
//   - fills the driver TX FIFO with opcode, optional address and optional payload;
//   - programs the TX length, wait-cycle count and RX length;
//   - pulses the go strobe and waits for the driver to finish;
//   - drains the RX FIFO into a byte stream for the flash-test controller.
//
// Ports:
//   i_ext_spi_clk_x, i_srst_n         clock, synchronous active-low reset
//   i_cmd_*, o_cmd_*                  command request / ready / done / error
//   i_wr_*, o_wr_ready                program payload stream (PAGE_PROG)
//   o_rd_data, o_rd_valid             read byte stream
//   o_tx_*, i_tx_ready                driver TX FIFO write side
//   o_tx_len, o_wait_cyc, o_rx_len    driver transaction lengths
//   o_go_stand, i_spi_idle            driver start strobe / idle status
//   i_rx_*, o_rx_dequeue              driver RX FIFO read side
module sf3_cmd_sequencer #(
    parameter int unsigned DUMMY_CYC    = 8,
    parameter int unsigned MAX_PROG_LEN = 256
) (
    input  logic        i_ext_spi_clk_x,
    input  logic        i_srst_n,
    input  logic        i_cmd_start,
    input  logic [2:0]  i_cmd_code,
    input  logic [23:0] i_cmd_addr,
    input  logic [10:0] i_cmd_len,
    output logic        o_cmd_ready,
    output logic        o_cmd_done,
    output logic        o_cmd_err,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_enqueue,
    input  logic        i_tx_ready,
    output logic [10:0] o_tx_len,
    output logic [8:0]  o_wait_cyc,
    output logic [10:0] o_rx_len,
    output logic        o_go_stand,
    input  logic        i_spi_idle,
    input  logic        i_rx_avail,
    output logic        o_rx_dequeue,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid
);

    localparam logic [2:0] CmdReadId   = 3'd0;
    localparam logic [2:0] CmdWriteEn  = 3'd1;
    localparam logic [2:0] CmdReadStat = 3'd2;
    localparam logic [2:0] CmdPageProg = 3'd3;
    localparam logic [2:0] CmdFastRead = 3'd4;
    localparam logic [2:0] CmdSectErase = 3'd5;

    localparam logic [10:0] MaxProgLen = 11'(MAX_PROG_LEN);
    localparam logic [8:0]  DummyCyc   = 9'(DUMMY_CYC);

    typedef enum logic [3:0] {
        StIdle,
        StLoadOp,
        StLoadAddr,
        StLoadData,
        StStart,
        StWaitBusy,
        StWaitIdle,
        StDrain,
        StDone
    } state_e;

    state_e      state_q;
    logic [2:0]  code_q;
    logic [23:0] addr_q;
    logic [10:0] len_q;
    logic [10:0] tx_len_q;
    logic [8:0]  wait_cyc_q;
    logic [10:0] rx_len_q;
    logic [10:0] cnt_q;       // address byte index, payload count or received count
    logic        rx_pend_q;   // a dequeue is outstanding, its data not yet returned
    logic        go_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;

    function automatic logic [7:0] opcode_of(input logic [2:0] code);
        case (code)
            CmdReadId:    opcode_of = 8'h9F;
            CmdWriteEn:   opcode_of = 8'h06;
            CmdReadStat:  opcode_of = 8'h05;
            CmdPageProg:  opcode_of = 8'h02;
            CmdFastRead:  opcode_of = 8'h0B;
            CmdSectErase: opcode_of = 8'hD8;
            default:      opcode_of = 8'h00;
        endcase
    endfunction

    function automatic logic has_addr(input logic [2:0] code);
        has_addr = (code == CmdPageProg) || (code == CmdFastRead) || (code == CmdSectErase);
    endfunction

    // Command validation and length computation on the incoming request.
    logic        cmd_bad;
    logic [10:0] new_tx_len;
    logic [10:0] new_rx_len;
    logic [8:0]  new_wait_cyc;

    always_comb begin
        cmd_bad = (i_cmd_code > CmdSectErase) ||
                  ((i_cmd_code == CmdPageProg) &&
                   ((i_cmd_len == 11'd0) || (i_cmd_len > MaxProgLen))) ||
                  ((i_cmd_code == CmdFastRead) && (i_cmd_len == 11'd0));

        new_tx_len = 11'd1;
        if (has_addr(i_cmd_code)) begin
            new_tx_len = new_tx_len + 11'd3;
        end
        if (i_cmd_code == CmdPageProg) begin
            new_tx_len = new_tx_len + i_cmd_len;
        end

        case (i_cmd_code)
            CmdReadId:   new_rx_len = 11'd3;
            CmdReadStat: new_rx_len = 11'd1;
            CmdFastRead: new_rx_len = i_cmd_len;
            default:     new_rx_len = 11'd0;
        endcase

        new_wait_cyc = (i_cmd_code == CmdFastRead) ? DummyCyc : 9'd0;
    end

    // TX enqueue is gated by i_tx_ready in the same cycle so a full FIFO is never written.
    always_comb begin
        o_tx_data    = 8'h00;
        o_tx_enqueue = 1'b0;
        o_wr_ready   = 1'b0;
        case (state_q)
            StLoadOp: begin
                o_tx_data    = opcode_of(code_q);
                o_tx_enqueue = i_tx_ready;
            end
            StLoadAddr: begin
                case (cnt_q[1:0])
                    2'd0:    o_tx_data = addr_q[23:16];
                    2'd1:    o_tx_data = addr_q[15:8];
                    default: o_tx_data = addr_q[7:0];
                endcase
                o_tx_enqueue = i_tx_ready;
            end
            StLoadData: begin
                o_wr_ready   = i_tx_ready;
                o_tx_data    = i_wr_data;
                o_tx_enqueue = i_wr_valid && i_tx_ready;
            end
            default: ;
        endcase
    end

    assign o_rx_dequeue = (state_q == StDrain) && i_rx_avail && !rx_pend_q &&
                          (cnt_q < rx_len_q);

    assign o_cmd_ready = (state_q == StIdle);
    assign o_cmd_done  = done_q;
    assign o_cmd_err   = err_q;
    assign o_go_stand  = go_q;
    assign o_tx_len    = tx_len_q;
    assign o_wait_cyc  = wait_cyc_q;
    assign o_rx_len    = rx_len_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;

    always_ff @(posedge i_ext_spi_clk_x) begin
        if (!i_srst_n) begin
            state_q    <= StIdle;
            code_q     <= 3'd0;
            addr_q     <= 24'd0;
            len_q      <= 11'd0;
            tx_len_q   <= 11'd0;
            wait_cyc_q <= 9'd0;
            rx_len_q   <= 11'd0;
            cnt_q      <= 11'd0;
            rx_pend_q  <= 1'b0;
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (i_cmd_start) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            code_q     <= i_cmd_code;
                            addr_q     <= i_cmd_addr;
                            len_q      <= i_cmd_len;
                            tx_len_q   <= new_tx_len;
                            rx_len_q   <= new_rx_len;
                            wait_cyc_q <= new_wait_cyc;
                            cnt_q      <= 11'd0;
                            state_q    <= StLoadOp;
                        end
                    end
                end
                StLoadOp: begin
                    if (i_tx_ready) begin
                        cnt_q   <= 11'd0;
                        state_q <= has_addr(code_q) ? StLoadAddr : StStart;
                    end
                end
                StLoadAddr: begin
                    if (i_tx_ready) begin
                        if (cnt_q == 11'd2) begin
                            cnt_q   <= 11'd0;
                            state_q <= (code_q == CmdPageProg) ? StLoadData : StStart;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end
                StLoadData: begin
                    if (i_wr_valid && i_tx_ready) begin
                        if (cnt_q == len_q - 11'd1) begin
                            cnt_q   <= 11'd0;
                            state_q <= StStart;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end
                StStart: begin
                    if (i_spi_idle) begin
                        go_q    <= 1'b1;
                        state_q <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (!i_spi_idle) begin
                        state_q <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (i_spi_idle) begin
                        cnt_q     <= 11'd0;
                        rx_pend_q <= 1'b0;
                        state_q   <= (rx_len_q != 11'd0) ? StDrain : StDone;
                    end
                end
                StDrain: begin
                    if (o_rx_dequeue) begin
                        rx_pend_q <= 1'b1;
                    end
                    if (i_rx_valid) begin
                        rx_pend_q  <= 1'b0;
                        rd_data_q  <= i_rx_data;
                        rd_valid_q <= 1'b1;
                        cnt_q      <= cnt_q + 11'd1;
                        if (cnt_q + 11'd1 == rx_len_q) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
